// File: rtl/linebuf_scheduler.sv
// Line-buffer sequencer: fetches image column words band by band, shifts them into the
// line buffer and offers a K-wide window handshake downstream once enough columns are resident.
module linebuf_scheduler #(
  parameter int unsigned BUF_HEIGHT      = 8,
  parameter int unsigned BUF_WIDTH       = 34,
  parameter int unsigned MAX_KERNEL_SIZE = 7,
  parameter int unsigned ADDR_W          = 10,
  localparam int unsigned CW = $clog2(BUF_WIDTH),
  localparam int unsigned KW = $clog2(MAX_KERNEL_SIZE + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [CW-1:0]         img_width,
  input  logic [ADDR_W-1:0]     num_bands,
  input  logic [KW-1:0]         kernel_size,
  output logic                  mem_rd_en,
  output logic [ADDR_W-1:0]     mem_addr,
  input  logic [BUF_HEIGHT-1:0] mem_rd_data,
  output logic [BUF_HEIGHT-1:0] buf_pixel,
  output logic                  buf_shift_enable,
  output logic                  buf_done,
  output logic [CW-1:0]         buf_img_width,
  output logic                  win_valid,
  input  logic                  win_ready,
  output logic [CW-1:0]         win_col,
  output logic [ADDR_W-1:0]     win_band,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  cfg_err
);

  typedef enum logic [2:0] {StIdle, StRead, StLoad, StWin, StDone} state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       col_q, col_d;
  logic [ADDR_W-1:0]   band_q, band_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [CW-1:0]       width_q, width_d;
  logic [ADDR_W-1:0]   bands_q, bands_d;
  logic [KW-1:0]       k_q, k_d;

  logic                rd_en_q, rd_en_d;
  logic [ADDR_W-1:0]   maddr_q, maddr_d;
  logic                shift_q, shift_d;
  logic                bdone_q, bdone_d;
  logic                wvalid_q, wvalid_d;
  logic [CW-1:0]       wcol_q, wcol_d;
  logic [ADDR_W-1:0]   wband_q, wband_d;
  logic                busy_q, busy_d;
  logic                fdone_q, fdone_d;
  logic                cfg_err_q, cfg_err_d;

  logic [31:0]         k32, w32;
  logic                cfg_bad;
  logic [CW-1:0]       k_ext;

  // Range checks done at 32 bits so out-of-range widths compare correctly.
  assign k32     = 32'(kernel_size);
  assign w32     = 32'(img_width);
  assign cfg_bad = (k32 == 32'd0) || (k32 > MAX_KERNEL_SIZE) || (w32 < k32) ||
                   (w32 > BUF_WIDTH) || (num_bands == '0);
  assign k_ext   = CW'(k_q);

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    band_d    = band_q;
    addr_d    = addr_q;
    width_d   = width_q;
    bands_d   = bands_q;
    k_d       = k_q;
    cfg_err_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (cfg_bad) begin
            cfg_err_d = 1'b1;
          end else begin
            width_d = img_width;
            bands_d = num_bands;
            k_d     = kernel_size;
            col_d   = '0;
            band_d  = '0;
            addr_d  = '0;
            state_d = StRead;
          end
        end
      end
      StRead: state_d = StLoad;
      StLoad: begin
        addr_d = addr_q + ADDR_W'(1);
        if (col_q >= k_ext - CW'(1)) begin
          state_d = StWin;
        end else begin
          col_d   = col_q + CW'(1);
          state_d = StRead;
        end
      end
      StWin: begin
        if (win_ready) begin
          if (col_q < width_q - CW'(1)) begin
            col_d   = col_q + CW'(1);
            state_d = StRead;
          end else if (band_q != bands_q - ADDR_W'(1)) begin
            col_d   = '0;
            band_d  = band_q + ADDR_W'(1);
            state_d = StRead;
          end else begin
            state_d = StDone;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Outputs are registered: decode them from the next state and next counters.
    rd_en_d  = (state_d == StRead);
    maddr_d  = (state_d == StRead) ? addr_d : '0;
    shift_d  = (state_d == StLoad);
    wvalid_d = (state_d == StWin);
    wcol_d   = (state_d == StWin) ? col_d : '0;
    wband_d  = (state_d == StWin) ? band_d : '0;
    busy_d   = (state_d == StRead) || (state_d == StLoad) || (state_d == StWin);
    bdone_d  = ~busy_d;
    fdone_d  = (state_d == StDone);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      col_q     <= '0;
      band_q    <= '0;
      addr_q    <= '0;
      width_q   <= '0;
      bands_q   <= '0;
      k_q       <= '0;
      rd_en_q   <= 1'b0;
      maddr_q   <= '0;
      shift_q   <= 1'b0;
      bdone_q   <= 1'b1;
      wvalid_q  <= 1'b0;
      wcol_q    <= '0;
      wband_q   <= '0;
      busy_q    <= 1'b0;
      fdone_q   <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      band_q    <= band_d;
      addr_q    <= addr_d;
      width_q   <= width_d;
      bands_q   <= bands_d;
      k_q       <= k_d;
      rd_en_q   <= rd_en_d;
      maddr_q   <= maddr_d;
      shift_q   <= shift_d;
      bdone_q   <= bdone_d;
      wvalid_q  <= wvalid_d;
      wcol_q    <= wcol_d;
      wband_q   <= wband_d;
      busy_q    <= busy_d;
      fdone_q   <= fdone_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign mem_rd_en        = rd_en_q;
  assign mem_addr         = maddr_q;
  // Read data only arrives during LOAD, so the pixel path is gated by the registered strobe.
  assign buf_pixel        = shift_q ? mem_rd_data : '0;
  assign buf_shift_enable = shift_q;
  assign buf_done         = bdone_q;
  assign buf_img_width    = width_q;
  assign win_valid        = wvalid_q;
  assign win_col          = wcol_q;
  assign win_band         = wband_q;
  assign busy             = busy_q;
  assign frame_done       = fdone_q;
  assign cfg_err          = cfg_err_q;

endmodule

// File: tb/tb_linebuf_scheduler.sv
// Scoreboard bench for linebuf_scheduler: stimulus pushes expected reads, windows, done and
// cfg_err events into queues; an independent monitor pops and compares as the DUT presents them.
module tb_linebuf_scheduler;
  localparam int BH = 8;
  localparam int BW = 34;
  localparam int MK = 7;
  localparam int AW = 10;
  localparam int CW = $clog2(BW);
  localparam int KW = $clog2(MK + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [CW-1:0] img_width;
  logic [AW-1:0] num_bands;
  logic [KW-1:0] kernel_size;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [BH-1:0] mem_rd_data = '0;
  logic [BH-1:0] buf_pixel;
  logic          buf_shift_enable;
  logic          buf_done;
  logic [CW-1:0] buf_img_width;
  logic          win_valid;
  logic          win_ready;
  logic [CW-1:0] win_col;
  logic [AW-1:0] win_band;
  logic          busy;
  logic          frame_done;
  logic          cfg_err;

  linebuf_scheduler #(
    .BUF_HEIGHT(BH), .BUF_WIDTH(BW), .MAX_KERNEL_SIZE(MK), .ADDR_W(AW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .img_width(img_width), .num_bands(num_bands),
    .kernel_size(kernel_size), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_rd_data(mem_rd_data), .buf_pixel(buf_pixel), .buf_shift_enable(buf_shift_enable),
    .buf_done(buf_done), .buf_img_width(buf_img_width), .win_valid(win_valid),
    .win_ready(win_ready), .win_col(win_col), .win_band(win_band), .busy(busy),
    .frame_done(frame_done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [BH-1:0] pat(input logic [AW-1:0] a);
    return 8'((int'(a) * 37) + 90);
  endfunction

  // Image memory: one-cycle read latency.
  always @(posedge clk) mem_rd_data <= mem_rd_en ? pat(mem_addr) : '0;

  typedef struct {int done_cyc; int busy_cyc;} done_t;
  int    exp_addr[$];
  int    exp_win[$];
  done_t exp_done[$];
  int    exp_cfg[$];
  int    start_cyc = 0;
  int    n_total = 0;
  int    n_bad = 0;

  task automatic check_eq(input string name, input int act, input int exp);
    n_total++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: samples 1 time unit after the falling edge.
  initial begin
    bit prev_rd = 0;
    bit prev_stall = 0;
    int held = 0;
    int last_addr = 0;
    int busy_cnt = 0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        prev_rd = 0; prev_stall = 0; busy_cnt = 0;
      end else begin
        int idx;
        idx = cyc - start_cyc + 1;
        if (busy) busy_cnt++;
        check_eq("buf_done_vs_busy", int'(buf_done), int'(!busy));
        if (mem_rd_en && buf_shift_enable) check_eq("rd_shift_overlap", 1, 0);
        if (mem_rd_en) begin
          check_eq("rd_during_stall", int'(prev_stall), 0);
          if (exp_addr.size() == 0) check_eq("unexpected_rd", int'(mem_addr), -1);
          else check_eq("mem_addr", int'(mem_addr), exp_addr.pop_front());
          last_addr = int'(mem_addr);
        end
        if (buf_shift_enable) begin
          check_eq("shift_after_rd", int'(prev_rd), 1);
          check_eq("buf_pixel", int'(buf_pixel), int'(pat(AW'(last_addr))));
        end
        if (win_valid) begin
          if (prev_stall) check_eq("win_hold", int'(win_band) * 64 + int'(win_col), held);
          if (win_ready) begin
            if (exp_win.size() == 0) check_eq("unexpected_win", int'(win_col), -1);
            else check_eq("win_band_col", int'(win_band) * 64 + int'(win_col),
                          exp_win.pop_front());
          end
        end
        prev_stall = win_valid && !win_ready;
        held = int'(win_band) * 64 + int'(win_col);
        if (frame_done) begin
          if (exp_done.size() == 0) check_eq("unexpected_done", idx, -1);
          else begin
            done_t d;
            d = exp_done.pop_front();
            check_eq("frame_done_cycle", idx, d.done_cyc);
            check_eq("busy_cycles", busy_cnt, d.busy_cyc);
          end
          busy_cnt = 0;
        end
        if (cfg_err) begin
          if (exp_cfg.size() == 0) check_eq("unexpected_cfg_err", idx, -1);
          else check_eq("cfg_err_cycle", idx, exp_cfg.pop_front());
        end
        prev_rd = mem_rd_en;
      end
    end
  end

  task automatic push_frame(input int k, input int w, input int b, input int stall);
    int lat;
    done_t d;
    for (int band = 0; band < b; band++) begin
      for (int c = 0; c < w; c++) begin
        exp_addr.push_back(band * w + c);
        if (c >= k - 1) exp_win.push_back(band * 64 + c);
      end
    end
    lat = b * (3 * w - k + 1) + stall;
    d.done_cyc = lat + 1;
    d.busy_cyc = lat;
    exp_done.push_back(d);
  endtask

  task automatic kick(input int k, input int w, input int b);
    @(negedge clk);
    kernel_size = KW'(k);
    img_width = CW'(w);
    num_bands = AW'(b);
    start = 1'b1;
    start_cyc = cyc + 1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic flush();
    exp_addr.delete();
    exp_win.delete();
    exp_done.delete();
    exp_cfg.delete();
  endtask

  task automatic wait_frame(input string name);
    int n = 0;
    while (exp_done.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check_eq({name, "_timeout"}, int'(n < 400), 1);
    repeat (3) @(negedge clk);
    check_eq({name, "_addr_left"}, exp_addr.size(), 0);
    check_eq({name, "_win_left"}, exp_win.size(), 0);
    flush();
  endtask

  task automatic wait_win(input string name);
    int n = 0;
    while (!win_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq({name, "_win_timeout"}, int'(n < 100), 1);
  endtask

  task automatic check_reset(input string name);
    check_eq({name, "_rd_en"}, int'(mem_rd_en), 0);
    check_eq({name, "_addr"}, int'(mem_addr), 0);
    check_eq({name, "_pixel"}, int'(buf_pixel), 0);
    check_eq({name, "_shift"}, int'(buf_shift_enable), 0);
    check_eq({name, "_buf_done"}, int'(buf_done), 1);
    check_eq({name, "_img_width"}, int'(buf_img_width), 0);
    check_eq({name, "_win_valid"}, int'(win_valid), 0);
    check_eq({name, "_win_col"}, int'(win_col), 0);
    check_eq({name, "_win_band"}, int'(win_band), 0);
    check_eq({name, "_busy"}, int'(busy), 0);
    check_eq({name, "_frame_done"}, int'(frame_done), 0);
    check_eq({name, "_cfg_err"}, int'(cfg_err), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    start = 1'b0;
    win_ready = 1'b1;
    img_width = '0;
    num_bands = '0;
    kernel_size = '0;
    #12;
    check_reset("por");
    @(negedge clk);
    rst = 1'b0;

    // Basic frame: K=3, width 5, one band.
    push_frame(3, 5, 1, 0);
    kick(3, 5, 1);
    wait_frame("basic");

    // First window stalled for 4 cycles.
    win_ready = 1'b0;
    push_frame(3, 5, 1, 4);
    kick(3, 5, 1);
    wait_win("stall");
    repeat (4) @(negedge clk);
    win_ready = 1'b1;
    wait_frame("stall");

    // Two bands, K=2.
    push_frame(2, 4, 2, 0);
    kick(2, 4, 2);
    wait_frame("bands");

    // Invalid configurations.
    exp_cfg.push_back(1);
    kick(0, 5, 1);
    repeat (3) begin @(negedge clk); check_eq("cfg_k0_busy", int'(busy), 0); end
    exp_cfg.push_back(1);
    kick(3, 2, 1);
    repeat (3) begin @(negedge clk); check_eq("cfg_narrow_busy", int'(busy), 0); end
    exp_cfg.push_back(1);
    kick(3, 5, 0);
    repeat (3) begin @(negedge clk); check_eq("cfg_nb0_busy", int'(busy), 0); end
    check_eq("cfg_err_left", exp_cfg.size(), 0);
    flush();

    // Asynchronous reset while parked in WIN, then a clean restart.
    win_ready = 1'b0;
    push_frame(3, 5, 1, 0);
    kick(3, 5, 1);
    wait_win("rst");
    #3;
    rst = 1'b1;
    #1;
    check_reset("midwin");
    flush();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    win_ready = 1'b1;
    push_frame(3, 5, 1, 0);
    kick(3, 5, 1);
    wait_frame("restart");

    // Start pulses during an active frame (with a different config) must be ignored.
    push_frame(3, 5, 1, 0);
    kick(3, 5, 1);
    repeat (2) @(negedge clk);
    kernel_size = KW'(2);
    img_width = CW'(9);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_win("ignore");
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_frame("ignore");
    check_eq("ignore_img_width", int'(buf_img_width), 5);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/linebuf_scheduler.md
# linebuf_scheduler

Sequencer for the convolution line buffer. After `start`, it walks the binarized image in column words (`BUF_HEIGHT` rows per word, one band at a time). It fetches each word from image memory, pushes the word into the line buffer with a one-cycle shift strobe, and offers a window handshake downstream once `kernel_size` columns of the current band are resident. It sits between the image memory and the line buffer / clause-evaluation datapath.

## Interface
- `BUF_HEIGHT`, 8: rows per column word; width of the line-buffer pixel input.
- `BUF_WIDTH`, 34: maximum image width in columns.
- `MAX_KERNEL_SIZE`, 7: largest supported kernel.
- `ADDR_W`, 10: image-memory word address width.
- `clk`  in  1  clock; all logic is rising-edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `start`  in  1  one-cycle request to begin a frame; sampled only in IDLE.
- `img_width`  in  $clog2(BUF_WIDTH)  columns per band; latched at start.
- `num_bands`  in  ADDR_W  number of bands; latched at start.
- `kernel_size`  in  $clog2(MAX_KERNEL_SIZE+1)  K; latched at start.
- `mem_rd_en`  out  1  image-memory read strobe.
- `mem_addr`  out  ADDR_W  word address.
- `mem_rd_data`  in  BUF_HEIGHT  read data, valid the cycle after `mem_rd_en`.
- `buf_pixel`  out  BUF_HEIGHT  column word driven into the line buffer.
- `buf_shift_enable`  out  1  line-buffer shift strobe.
- `buf_done`  out  1  line-buffer freeze; 1 whenever not busy.
- `buf_img_width`  out  $clog2(BUF_WIDTH)  latched `img_width`.
- `win_valid`  out  1  a K-wide window is resident.
- `win_ready`  in  1  downstream accepts the window.
- `win_col`  out  $clog2(BUF_WIDTH)  column index of the newest column in the window.
- `win_band`  out  ADDR_W  current band index.
- `busy`  out  1  frame in progress.
- `frame_done`  out  1  one-cycle pulse at end of frame.
- `cfg_err`  out  1  one-cycle pulse when `start` carries an invalid configuration.

## Operation
- FSM states: IDLE, READ, LOAD, WIN, DONE. All outputs are registered (Moore).
- **IDLE**
  - Entered on `start` = 1 with a valid configuration; latches the configuration, clears the column, band and address counters, and moves to READ.
  - A configuration is invalid if K = 0, K > `MAX_KERNEL_SIZE`, `img_width` < K, `img_width` > `BUF_WIDTH`, or `num_bands` = 0. On an invalid configuration: `cfg_err` pulses and the FSM stays in IDLE.
- **READ**
  - `mem_rd_en` = 1 and `mem_addr` = running address.
  - Next state is LOAD.
- **LOAD**
  - `buf_shift_enable` = 1 and `buf_pixel` = `mem_rd_data`. The address increments.
  - If the column index c ≥ K−1, next state is WIN.
  - Otherwise c increments and the next state is READ.
- **WIN**
  - `win_valid` = 1, `win_col` = c, `win_band` = current band.
  - The FSM holds in WIN while `win_ready` = 0. Handshake rule: `win_valid` stays asserted, and `win_col` / `win_band` stay stable, until `win_ready` is sampled high.
  - On acceptance:
    - If c < `img_width`−1: c increments and the next state is READ.
    - Else if the band is not the last: c returns to 0, the band increments, and the next state is READ. The first K−1 columns of the new band produce no window.
    - Else the next state is DONE.
- **DONE**
  - `frame_done` = 1 for one cycle; next state is IDLE.
- `busy` = 1 in READ, LOAD and WIN. `buf_done` = ~`busy`.
- Address arithmetic:
  - The address counts 0 … `img_width`·`num_bands`−1, incrementing by 1 per LOAD.
  - The counter is ADDR_W bits and wraps modulo 2^ADDR_W; software sizes frames to fit.
- A `start` that arrives while not in IDLE is ignored.
- An asynchronous `rst` at any point returns the FSM to IDLE immediately and clears all counters and latched configuration.
- Reset values: every output is 0 except `buf_done` = 1.

## Timing
- With `start` sampled at edge 0: READ during cycle 1, LOAD during cycle 2.
- Per column with `win_ready` held at 1:
  - 2 cycles for columns with c < K−1.
  - 3 cycles for columns with c ≥ K−1.
- Frame latency with `win_ready` = 1: `num_bands`·(2·`img_width` + (`img_width`−K+1)) cycles, followed by a 1-cycle DONE.
- A `win_ready` stall adds exactly one cycle per cycle held low; no reads and no shifts occur during a stall.
- `mem_rd_en` and `buf_shift_enable` are never high in the same cycle.

## Test plan
- K=3, `img_width`=5, `num_bands`=1, `win_ready`=1:
  - `mem_addr` 0,1,2,3,4, each followed by exactly one `buf_shift_enable` carrying that word.
  - `win_valid` with `win_col` = 2, 3, 4.
  - `frame_done` pulses at cycle 14 after `start`; `busy` is high for 13 cycles.
- Same configuration with `win_ready` = 0 for 4 cycles on the first window:
  - `win_valid` held with `win_col` = 2 throughout; no `mem_rd_en` during the stall.
  - `frame_done` pulses 4 cycles later (cycle 18).
- K=2, `img_width`=4, `num_bands`=2:
  - Addresses 0–7 in order.
  - Windows (band, col) = (0,1), (0,2), (0,3), (1,1), (1,2), (1,3); no window at (1,0).
- Invalid configurations: `start` with K=0, then with `img_width`=2 and K=3, then with `num_bands`=0:
  - Each gives a single `cfg_err` pulse; `busy` stays 0 and `mem_rd_en` is never asserted.
- `rst` asserted asynchronously mid-frame, in the middle of the WIN state:
  - All outputs go to reset values without waiting for a clock edge (`buf_done` = 1).
  - A subsequent valid `start` restarts the frame from address 0.
- `start` pulsed during an active frame:
  - Ignored; the address sequence and `frame_done` timing are identical to the undisturbed frame.
